// File: rtl/load_unit_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : load_unit_fsm
//  Description : RV32I data-memory load path. Accepts a load from execute,
//                issues a word-aligned read, waits a variable latency for the
//                data, extracts byte/half/word and sign/zero-extends it.
//                Stalls upstream while busy and flags misaligned/illegal
//                loads and memory timeouts.
//  Revision    : 1.0 - initial release
// ============================================================================
module load_unit_fsm #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        load_req_in,
    input  logic [2:0]  fun_3_in,
    input  logic [31:0] iadder_in,
    output logic        dm_rd_req_o,
    output logic [31:0] dm_addr_o,
    input  logic        dm_ack_in,
    input  logic        dm_rvalid_in,
    input  logic [31:0] dm_rdata_in,
    output logic [31:0] lu_output_o,
    output logic        lu_valid_o,
    output logic        misaligned_o,
    output logic        bus_err_o,
    output logic        stall_o
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LIMIT = c_CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [2:0] c_F3_LB  = 3'b000;
    localparam logic [2:0] c_F3_LH  = 3'b001;
    localparam logic [2:0] c_F3_LW  = 3'b010;
    localparam logic [2:0] c_F3_LBU = 3'b100;
    localparam logic [2:0] c_F3_LHU = 3'b101;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_DONE = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    // ------------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------------
    state_t               r_state;
    state_t               w_state_nxt;

    logic [2:0]           r_fun3;
    logic [1:0]           r_addr_lo;
    logic                 r_dm_rd_req;
    logic [31:0]          r_dm_addr;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [31:0]          r_lu_output;
    logic                 r_bus_err;

    logic                 w_accept;     // load taken in IDLE (legal or not)
    logic                 w_misaligned; // address/funct3 check on live inputs
    logic                 w_issue;      // legal load: start a memory read
    logic                 w_at_limit;   // timeout counter at its last cycle
    logic                 w_timeout;    // abort the in-flight load
    logic                 w_complete;   // read data arrives while waiting
    logic                 w_req_drop;   // request line falls next cycle

    logic [7:0]           w_byte;
    logic [15:0]          w_half;
    logic [31:0]          w_extracted;

    // ------------------------------------------------------------------------
    // Alignment / legality check on the incoming load
    // ------------------------------------------------------------------------
    // Classify the execute-stage request as illegal or misaligned
    always_comb begin
        w_misaligned = 1'b0;
        case (fun_3_in)
            c_F3_LB,
            c_F3_LBU: w_misaligned = 1'b0;
            c_F3_LH,
            c_F3_LHU: w_misaligned = iadder_in[0];
            c_F3_LW:  w_misaligned = (iadder_in[1:0] != 2'b00);
            default:  w_misaligned = 1'b1;   // 011, 110, 111 are not loads
        endcase
    end

    assign w_accept   = (r_state == S_IDLE) && load_req_in;
    assign w_issue    = w_accept && !w_misaligned;
    assign w_at_limit = (r_cnt == c_CNT_LIMIT);
    assign w_complete = (r_state == S_WAIT) && dm_rvalid_in;

    // Timeout applies in REQ and WAIT; arriving read data takes priority.
    // An ack on the last allowed REQ cycle does not extend the budget.
    assign w_timeout  = ((r_state == S_REQ) || (r_state == S_WAIT))
                        && w_at_limit && !w_complete;

    assign w_req_drop = (r_state == S_REQ) && (dm_ack_in || w_at_limit);

    // ------------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------------
    // State register
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (load_req_in) begin
                    w_state_nxt = w_misaligned ? S_ERR : S_REQ;
                end
            end
            S_REQ: begin
                if (w_at_limit) begin
                    w_state_nxt = S_IDLE;
                end else if (dm_ack_in) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (dm_rvalid_in) begin
                    w_state_nxt = S_DONE;
                end else if (w_at_limit) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            S_ERR:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------------
    // Capture funct3 and low address bits for later extraction
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_fun3    <= 3'b000;
            r_addr_lo <= 2'b00;
        end else if (w_accept) begin
            r_fun3    <= fun_3_in;
            r_addr_lo <= iadder_in[1:0];
        end
    end

    // Memory request line and word-aligned address, held stable until ack
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_dm_rd_req <= 1'b0;
            r_dm_addr   <= 32'h0;
        end else if (w_issue) begin
            r_dm_rd_req <= 1'b1;
            r_dm_addr   <= {iadder_in[31:2], 2'b00};
        end else if (w_req_drop) begin
            r_dm_rd_req <= 1'b0;
        end
    end

    // Cycles spent in REQ+WAIT, cleared when a new read is issued
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_cnt <= '0;
        end else if (w_issue) begin
            r_cnt <= '0;
        end else if ((r_state == S_REQ) || (r_state == S_WAIT)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Lane extraction and extension
    // ------------------------------------------------------------------------
    // Select byte/half by latched address and extend per latched funct3
    always_comb begin
        w_byte      = 8'h00;
        w_half      = 16'h0000;
        w_extracted = 32'h0;

        case (r_addr_lo)
            2'b00:   w_byte = dm_rdata_in[7:0];
            2'b01:   w_byte = dm_rdata_in[15:8];
            2'b10:   w_byte = dm_rdata_in[23:16];
            default: w_byte = dm_rdata_in[31:24];
        endcase

        w_half = r_addr_lo[1] ? dm_rdata_in[31:16] : dm_rdata_in[15:0];

        case (r_fun3)
            c_F3_LB:  w_extracted = {{24{w_byte[7]}}, w_byte};
            c_F3_LBU: w_extracted = {24'h0, w_byte};
            c_F3_LH:  w_extracted = {{16{w_half[15]}}, w_half};
            c_F3_LHU: w_extracted = {16'h0, w_half};
            c_F3_LW:  w_extracted = dm_rdata_in;
            default:  w_extracted = dm_rdata_in;
        endcase
    end

    // Result register: only updated by a completed read
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_lu_output <= 32'h0;
        end else if (w_complete) begin
            r_lu_output <= w_extracted;
        end
    end

    // Bus-error pulse follows the cycle in which the budget ran out
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_bus_err <= 1'b0;
        end else begin
            r_bus_err <= w_timeout;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign dm_rd_req_o  = r_dm_rd_req;
    assign dm_addr_o    = r_dm_addr;
    assign lu_output_o  = r_lu_output;
    assign lu_valid_o   = (r_state == S_DONE);
    assign misaligned_o = (r_state == S_ERR);
    assign bus_err_o    = r_bus_err;
    // Combinational so the requesting instruction freezes in its issue cycle
    assign stall_o      = (r_state != S_IDLE) || load_req_in;

endmodule
`default_nettype wire

// File: tb/tb_load_unit_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : tb_load_unit_fsm
//  Description : Self-checking bench for load_unit_fsm (TIMEOUT_CYCLES=4).
//                Table of single loads plus hand-written multi-cycle cases.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_load_unit_fsm;

    logic        clk_in;
    logic        rst_in;
    logic        load_req_in;
    logic [2:0]  fun_3_in;
    logic [31:0] iadder_in;
    logic        dm_rd_req_o;
    logic [31:0] dm_addr_o;
    logic        dm_ack_in;
    logic        dm_rvalid_in;
    logic [31:0] dm_rdata_in;
    logic [31:0] lu_output_o;
    logic        lu_valid_o;
    logic        misaligned_o;
    logic        bus_err_o;
    logic        stall_o;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] prev_out;

    load_unit_fsm #(.TIMEOUT_CYCLES(4)) dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .load_req_in  (load_req_in),
        .fun_3_in     (fun_3_in),
        .iadder_in    (iadder_in),
        .dm_rd_req_o  (dm_rd_req_o),
        .dm_addr_o    (dm_addr_o),
        .dm_ack_in    (dm_ack_in),
        .dm_rvalid_in (dm_rvalid_in),
        .dm_rdata_in  (dm_rdata_in),
        .lu_output_o  (lu_output_o),
        .lu_valid_o   (lu_valid_o),
        .misaligned_o (misaligned_o),
        .bus_err_o    (bus_err_o),
        .stall_o      (stall_o)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] rdata;
        logic        misal;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    // One load, minimum-latency handshake; misaligned ones must not touch memory
    task automatic run_load(input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] rdata, input logic misal,
                            input logic [31:0] exp);
        load_req_in = 1'b1;
        fun_3_in    = f3;
        iadder_in   = addr;
        #1;
        check("stall_issue", stall_o, 1);
        tick();                                   // cycle 1
        load_req_in = 1'b0;
        if (misal) begin
            check("misal_pulse", misaligned_o, 1);
            check("misal_noreq", dm_rd_req_o, 0);
            check("misal_out_held", lu_output_o, prev_out);
            tick();
            check("misal_end", misaligned_o, 0);
            check("misal_noreq2", dm_rd_req_o, 0);
            check("misal_idle", stall_o, 0);
        end else begin
            check("rd_req", dm_rd_req_o, 1);
            check("rd_addr", dm_addr_o, {addr[31:2], 2'b00});
            check("no_misal", misaligned_o, 0);
            dm_ack_in = 1'b1;
            tick();                               // cycle 2: WAIT
            dm_ack_in = 1'b0;
            check("req_drop", dm_rd_req_o, 0);
            dm_rvalid_in = 1'b1;
            dm_rdata_in  = rdata;
            tick();                               // cycle 3: DONE
            dm_rvalid_in = 1'b0;
            check("lu_valid", lu_valid_o, 1);
            check("lu_output", lu_output_o, exp);
            prev_out = exp;
            tick();
            check("lu_valid_end", lu_valid_o, 0);
            check("idle_stall", stall_o, 0);
        end
    endtask

    // LW with no data; optional ack, optional rvalid on the limit cycle
    task automatic timeout_seq(input logic do_ack, input logic rv_at_limit);
        load_req_in = 1'b1;
        fun_3_in    = 3'b010;
        iadder_in   = 32'h0000_0300;
        tick();                                   // cycle 1: REQ, cnt 0
        load_req_in = 1'b0;
        dm_ack_in   = do_ack;
        tick();                                   // cycle 2: cnt 1
        dm_ack_in   = 1'b0;
        tick();                                   // cycle 3: cnt 2
        check("to_no_err_early", bus_err_o, 0);
        tick();                                   // cycle 4: cnt 3 = limit
        check("to_no_err_limit", bus_err_o, 0);
        check("to_stall_limit", stall_o, 1);
        check("to_req_at_limit", dm_rd_req_o, !do_ack);
        if (rv_at_limit) begin
            dm_rvalid_in = 1'b1;
            dm_rdata_in  = 32'hCAFE_F00D;
        end
        tick();                                   // cycle 5
        dm_rvalid_in = 1'b0;
        if (rv_at_limit) begin
            check("to_data_wins_valid", lu_valid_o, 1);
            check("to_data_wins_out", lu_output_o, 32'hCAFE_F00D);
            check("to_data_wins_noerr", bus_err_o, 0);
            prev_out = 32'hCAFE_F00D;
        end else begin
            check("to_bus_err", bus_err_o, 1);
            check("to_no_valid", lu_valid_o, 0);
            check("to_out_held", lu_output_o, prev_out);
            check("to_req_low", dm_rd_req_o, 0);
            check("to_idle", stall_o, 0);
        end
        tick();                                   // cycle 6
        check("to_err_end", bus_err_o, 0);
        check("to_valid_end", lu_valid_o, 0);
    endtask

    initial begin
        vecs[0]  = '{3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF};
        vecs[1]  = '{3'b000, 32'h0000_0103, 32'h80FF_1234, 1'b0, 32'hFFFF_FF80};
        vecs[2]  = '{3'b100, 32'h0000_0103, 32'h80FF_1234, 1'b0, 32'h0000_0080};
        vecs[3]  = '{3'b001, 32'h0000_0102, 32'h80FF_1234, 1'b0, 32'hFFFF_80FF};
        vecs[4]  = '{3'b101, 32'h0000_0100, 32'h80FF_1234, 1'b0, 32'h0000_1234};
        vecs[5]  = '{3'b000, 32'h0000_0100, 32'h80FF_1234, 1'b0, 32'h0000_0034};
        vecs[6]  = '{3'b100, 32'h0000_0101, 32'h80FF_1234, 1'b0, 32'h0000_0012};
        vecs[7]  = '{3'b000, 32'h0000_0102, 32'h80FF_1234, 1'b0, 32'hFFFF_FFFF};
        vecs[8]  = '{3'b101, 32'hABCD_0102, 32'h80FF_1234, 1'b0, 32'h0000_80FF};
        vecs[9]  = '{3'b001, 32'h0000_0100, 32'h80FF_1234, 1'b0, 32'h0000_1234};
        vecs[10] = '{3'b001, 32'h0000_0101, 32'h0,         1'b1, 32'h0};
        vecs[11] = '{3'b010, 32'h0000_0102, 32'h0,         1'b1, 32'h0};
        vecs[12] = '{3'b011, 32'h0000_0100, 32'h0,         1'b1, 32'h0};
        vecs[13] = '{3'b101, 32'h0000_0103, 32'h0,         1'b1, 32'h0};
        vecs[14] = '{3'b110, 32'h0000_0100, 32'h0,         1'b1, 32'h0};
        vecs[15] = '{3'b111, 32'h0000_0104, 32'h0,         1'b1, 32'h0};

        rst_in       = 1'b1;
        load_req_in  = 1'b0;
        fun_3_in     = 3'b000;
        iadder_in    = 32'h0;
        dm_ack_in    = 1'b0;
        dm_rvalid_in = 1'b0;
        dm_rdata_in  = 32'h0;
        prev_out     = 32'h0;
        tick();
        tick();
        rst_in = 1'b0;
        tick();

        // Reset state
        check("rst_rd_req", dm_rd_req_o, 0);
        check("rst_addr", dm_addr_o, 32'h0);
        check("rst_output", lu_output_o, 32'h0);
        check("rst_valid", lu_valid_o, 0);
        check("rst_misal", misaligned_o, 0);
        check("rst_bus_err", bus_err_o, 0);
        check("rst_stall", stall_o, 0);

        // Table of single loads
        for (int i = 0; i < 16; i++) begin
            run_load(vecs[i].f3, vecs[i].addr, vecs[i].rdata, vecs[i].misal, vecs[i].exp);
        end

        // Ack held off: request stable, stray rvalid in REQ ignored,
        // load_req during DONE ignored
        load_req_in = 1'b1;
        fun_3_in    = 3'b010;
        iadder_in   = 32'h0000_0208;
        tick();                                   // cycle 1
        load_req_in = 1'b0;
        check("hold_req1", dm_rd_req_o, 1);
        check("hold_addr1", dm_addr_o, 32'h0000_0208);
        check("hold_stall1", stall_o, 1);
        dm_rvalid_in = 1'b1;
        dm_rdata_in  = 32'hBAD0_BAD0;
        tick();                                   // cycle 2
        dm_rvalid_in = 1'b0;
        check("hold_req2", dm_rd_req_o, 1);
        check("hold_addr2", dm_addr_o, 32'h0000_0208);
        check("stray_rv_novalid", lu_valid_o, 0);
        check("hold_stall2", stall_o, 1);
        tick();                                   // cycle 3
        check("hold_req3", dm_rd_req_o, 1);
        check("hold_addr3", dm_addr_o, 32'h0000_0208);
        check("stray_rv_out", lu_output_o, prev_out);
        dm_ack_in = 1'b1;
        tick();                                   // cycle 4: WAIT
        dm_ack_in = 1'b0;
        check("hold_req_drop", dm_rd_req_o, 0);
        check("hold_wait_stall", stall_o, 1);
        dm_rvalid_in = 1'b1;
        dm_rdata_in  = 32'h1122_3344;
        tick();                                   // cycle 5: DONE
        dm_rvalid_in = 1'b0;
        check("hold_valid", lu_valid_o, 1);
        check("hold_output", lu_output_o, 32'h1122_3344);
        prev_out = 32'h1122_3344;
        load_req_in = 1'b1;
        fun_3_in    = 3'b010;
        iadder_in   = 32'h0000_0400;
        #1;
        check("done_stall", stall_o, 1);
        tick();                                   // IDLE
        check("done_req_ignored", dm_rd_req_o, 0);
        check("done_valid_end", lu_valid_o, 0);
        load_req_in = 1'b0;
        #1;
        check("idle_stall_after", stall_o, 0);
        tick();
        check("done_still_idle", dm_rd_req_o, 0);

        // Stray rvalid in IDLE
        dm_rvalid_in = 1'b1;
        dm_rdata_in  = 32'h7777_7777;
        tick();
        dm_rvalid_in = 1'b0;
        check("idle_rv_novalid", lu_valid_o, 0);
        check("idle_rv_out", lu_output_o, prev_out);

        // Timeout cases
        timeout_seq(1'b1, 1'b0);
        timeout_seq(1'b0, 1'b0);
        timeout_seq(1'b1, 1'b1);

        // Reset while waiting for data
        load_req_in = 1'b1;
        fun_3_in    = 3'b010;
        iadder_in   = 32'h0000_0500;
        tick();
        load_req_in = 1'b0;
        dm_ack_in   = 1'b1;
        tick();                                   // WAIT
        dm_ack_in   = 1'b0;
        rst_in      = 1'b1;
        tick();
        rst_in      = 1'b0;
        check("wrst_rd_req", dm_rd_req_o, 0);
        check("wrst_addr", dm_addr_o, 32'h0);
        check("wrst_output", lu_output_o, 32'h0);
        check("wrst_valid", lu_valid_o, 0);
        check("wrst_stall", stall_o, 0);
        prev_out = 32'h0;
        dm_rvalid_in = 1'b1;
        dm_rdata_in  = 32'h9999_9999;
        tick();
        dm_rvalid_in = 1'b0;
        check("wrst_late_rv_valid", lu_valid_o, 0);
        check("wrst_late_rv_out", lu_output_o, 32'h0);
        run_load(3'b010, 32'h0000_0104, 32'h55AA_55AA, 1'b0, 32'h55AA_55AA);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Absolute bound on run time
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
